fc2_output_accumulator: RTL and testbench

// - Consumer side of the 10-lane FC2 multiplier array (one input x 10 weights per beat).
// - Each beat carries 10 products; lane k accumulates its product into a running sum.
// - The bias is added on the first beat; after NUM_INPUTS beats the block presents 10 class scores.
// - Sits between the FC2 product stage and the argmax / output stage of the LeNet5 datapath.

---
 rtl/fc2_output_accumulator_pkg.sv | 23 ++
 rtl/Adder.sv | 95 +++++++++
 rtl/fc2_output_accumulator_acc_lane.sv | 40 ++++
 rtl/fc2_output_accumulator.sv | 92 +++++++++
 tb/tb_fc2_output_accumulator.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fc2_output_accumulator_pkg.sv
// FC2 output accumulator shared definitions.
// Lane count, arithmetic codes, lane slicing and float constants.
package fc2_output_accumulator_pkg;

    localparam int FC2_LANES   = 10;
    localparam int ARITH_INT   = 0;
    localparam int ARITH_FLOAT = 1;

    localparam logic [31:0] FP_ONE  = 32'h3F800000;
    localparam logic [31:0] FP_HALF = 32'h3F000000;
    localparam logic [31:0] FP_2P5  = 32'h40200000;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } acc_state_t;

    // Low bit index of lane k in a packed multi-lane bus.
    function automatic int lane_lo(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/Adder.sv
// Shared combinational adder: integer (modulo 2^DW) or IEEE-754 single.
// Float path rounds to nearest even and handles zero/denormal/inf/NaN.
module Adder
    import fc2_output_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ARITH_TYPE = ARITH_FLOAT
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    generate
        if (ARITH_TYPE == ARITH_INT) begin : g_int
            assign y = a + b;
        end else begin : g_flt
            logic [31:0] fa, fb, big, sml, r;
            logic [7:0]  eb, es, d;
            logic [26:0] mb, ms, mask;
            logic [27:0] s;
            logic [9:0]  e;
            logic [24:0] m;
            logic        st, rnd;

            // Align, add/subtract, normalise, round, then patch special values.
            always_comb begin
                fa = 32'(a);
                fb = 32'(b);
                if (fa[30:0] >= fb[30:0]) begin
                    big = fa;
                    sml = fb;
                end else begin
                    big = fb;
                    sml = fa;
                end
                eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
                es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
                mb = {big[30:23] != 8'd0, big[22:0], 3'b000};
                ms = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
                d  = eb - es;
                mask = '0;
                st = 1'b0;
                if (d > 8'd26) begin
                    st = |ms;
                    ms = '0;
                end else begin
                    mask = (27'd1 << d) - 27'd1;
                    st = |(ms & mask);
                    ms = ms >> d;
                end
                ms[0] = ms[0] | st;
                e = {2'b00, eb};
                if (big[31] == sml[31])
                    s = {1'b0, mb} + {1'b0, ms};
                else
                    s = {1'b0, mb} - {1'b0, ms};
                if (s[27]) begin
                    s = {1'b0, s[27:2], s[1] | s[0]};
                    e = e + 10'd1;
                end
                for (int i = 0; i < 26; i++) begin
                    if (!s[26] && e > 10'd1 && s != '0) begin
                        s = s << 1;
                        e = e - 10'd1;
                    end
                end
                rnd = s[2] && (s[1] || s[0] || s[3]);
                m = {1'b0, s[26:3]} + {24'd0, rnd};
                if (m[24]) begin
                    m = m >> 1;
                    e = e + 10'd1;
                end
                if (s == '0)
                    r = {big[31] & sml[31], 31'd0};
                else if (e >= 10'd255)
                    r = {big[31], 8'hFF, 23'd0};
                else
                    r = {big[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
                if (fa[30:23] == 8'hFF || fb[30:23] == 8'hFF) begin
                    if ((fa[30:23] == 8'hFF && fa[22:0] != 23'd0) ||
                        (fb[30:23] == 8'hFF && fb[22:0] != 23'd0) ||
                        (fa[30:23] == 8'hFF && fb[30:23] == 8'hFF &&
                         fa[31] != fb[31]))
                        r = 32'h7FC00000;
                    else
                        r = (fa[30:23] == 8'hFF) ? fa : fb;
                end
            end

            assign y = DATA_WIDTH'(r);
        end
    endgenerate

endmodule

// File: rtl/fc2_output_accumulator_acc_lane.sv
// One FC2 output lane: running-sum register fed by the shared Adder.
// First beat of a result adds the product to the bias instead of acc.
module fc2_acc_lane
    import fc2_output_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ARITH_TYPE = ARITH_FLOAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_bias,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] bias,
    input  logic [DATA_WIDTH-1:0] prod,
    output logic [DATA_WIDTH-1:0] acc
);

    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] sum;

    assign base = load_bias ? bias : acc;

    Adder #(
        .DATA_WIDTH(DATA_WIDTH),
        .ARITH_TYPE(ARITH_TYPE)
    ) u_add (
        .a(base),
        .b(prod),
        .y(sum)
    );

    // Capture the new running sum on every accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/fc2_output_accumulator.sv
// FC2 output accumulator: 10 lanes summing NUM_INPUTS product beats plus bias.
// Holds the finished scores until downstream accepts them.
module fc2_output_accumulator
    import fc2_output_accumulator_pkg::*;
#(
    parameter int ARITH_TYPE = ARITH_FLOAT,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 84
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [FC2_LANES*DATA_WIDTH-1:0] prod_in,
    input  logic [FC2_LANES*DATA_WIDTH-1:0] bias_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [FC2_LANES*DATA_WIDTH-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy
);

    localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_INPUTS - 1);

    acc_state_t    state;
    logic [CW-1:0] cnt;
    logic          beat;

    // A flushed cycle never counts as a beat.
    assign beat = in_valid && in_ready && !flush;
    assign busy = (state == ST_ACC) && (cnt != '0);

    // Beat counter and ACC/OUT handshake with registered flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ACC;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= ST_ACC;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                ST_ACC: begin
                    if (beat) begin
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            state     <= ST_OUT;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state     <= ST_ACC;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

    genvar k;
    generate
        for (k = 0; k < FC2_LANES; k++) begin : g_lane
            fc2_acc_lane #(
                .DATA_WIDTH(DATA_WIDTH),
                .ARITH_TYPE(ARITH_TYPE)
            ) u_lane (
                .clk      (clk),
                .reset    (reset),
                .load_bias(cnt == '0),
                .en       (beat),
                .bias     (bias_in[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
                .prod     (prod_in[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
                .acc      (out_data[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fc2_output_accumulator.sv
// Bench for fc2_output_accumulator: directed cases plus random traffic.
// Reference keeps each result's beats in a queue and sums them at the end.
module tb_fc2_output_accumulator;
    import fc2_output_accumulator_pkg::*;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int L  = FC2_LANES;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [L*DW-1:0] prod_in, bias_in, out_data;

    fc2_output_accumulator #(
        .ARITH_TYPE(ARITH_INT), .DATA_WIDTH(DW), .NUM_INPUTS(N)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .prod_in(prod_in), .bias_in(bias_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    logic w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
    logic [L*16-1:0] w_prod, w_bias, w_out;

    fc2_output_accumulator #(
        .ARITH_TYPE(ARITH_INT), .DATA_WIDTH(16), .NUM_INPUTS(2)
    ) dut_wrap (
        .clk(clk), .reset(reset), .flush(w_flush),
        .prod_in(w_prod), .bias_in(w_bias),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .out_data(w_out), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .busy(w_busy)
    );

    logic f_flush, f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_busy;
    logic [L*32-1:0] f_prod, f_bias, f_out;

    fc2_output_accumulator #(
        .ARITH_TYPE(ARITH_FLOAT), .DATA_WIDTH(32), .NUM_INPUTS(2)
    ) dut_flt (
        .clk(clk), .reset(reset), .flush(f_flush),
        .prod_in(f_prod), .bias_in(f_bias),
        .in_valid(f_in_valid), .in_ready(f_in_ready),
        .out_data(f_out), .out_valid(f_out_valid),
        .out_ready(f_out_ready), .busy(f_busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference: beats of the open result, its bias, and the pending result.
    logic [L*DW-1:0] grp[$];
    logic [L*DW-1:0] grp_bias;
    logic [L*DW-1:0] exp_out;
    bit              holding;

    function automatic logic [L*DW-1:0] result_of();
        logic [L*DW-1:0] r;
        logic [DW-1:0]   s;
        for (int k = 0; k < L; k++) begin
            s = grp_bias[k*DW +: DW];
            foreach (grp[i]) s = s + grp[i][k*DW +: DW];
            r[k*DW +: DW] = s;
        end
        return r;
    endfunction

    function automatic logic [L*DW-1:0] lanes(input int base, input int step);
        logic [L*DW-1:0] v;
        for (int k = 0; k < L; k++) v[k*DW +: DW] = DW'(base + step * k);
        return v;
    endfunction

    function automatic logic [L*DW-1:0] rnd_vec();
        logic [L*DW-1:0] v;
        for (int k = 0; k < L; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic cyc(input bit v, input bit fl, input bit ordy,
                       input logic [L*DW-1:0] p, input logic [L*DW-1:0] b);
        in_valid  = v;
        flush     = fl;
        out_ready = ordy;
        prod_in   = p;
        bias_in   = b;
        @(posedge clk);
        #1;
        if (fl) begin
            grp.delete();
            holding = 1'b0;
        end else if (holding) begin
            if (ordy) holding = 1'b0;
        end else if (v) begin
            if (grp.size() == 0) grp_bias = b;
            grp.push_back(p);
            if (grp.size() == N) begin
                exp_out = result_of();
                grp.delete();
                holding = 1'b1;
            end
        end
        chk("out_valid", out_valid, holding);
        chk("in_ready", in_ready, !holding);
        chk("busy", busy, !holding && grp.size() != 0);
        if (holding)
            for (int k = 0; k < L; k++)
                chk("out_lane", out_data[k*DW +: DW], exp_out[k*DW +: DW]);
    endtask

    logic [L*DW-1:0] bb, bp, one;

    initial begin
        reset = 1'b1;
        flush = 0; in_valid = 0; out_ready = 0;
        prod_in = '0; bias_in = '0;
        w_flush = 0; w_in_valid = 0; w_out_ready = 0;
        w_prod = '0; w_bias = '0;
        f_flush = 0; f_in_valid = 0; f_out_ready = 0;
        f_prod = '0; f_bias = '0;
        holding = 1'b0;
        grp_bias = '0;
        exp_out = '0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_data", |out_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Wrap and float instances: two beats each.
        for (int k = 0; k < L; k++) begin
            w_prod[k*16 +: 16] = 16'h7FFF;
            f_prod[k*32 +: 32] = FP_ONE;
            f_bias[k*32 +: 32] = FP_HALF;
        end
        w_in_valid = 1;
        f_in_valid = 1;
        @(posedge clk);
        #1;
        chk("wrap_mid_valid", w_out_valid, 0);
        @(posedge clk);
        #1;
        w_in_valid = 0;
        f_in_valid = 0;
        chk("wrap_valid", w_out_valid, 1);
        chk("flt_valid", f_out_valid, 1);
        for (int k = 0; k < L; k++) begin
            chk("wrap_lane", w_out[k*16 +: 16], 16'hFFFE);
            chk("flt_lane", f_out[k*32 +: 32], FP_2P5);
        end

        // Basic.
        bb = lanes(0, 10);
        bp = lanes(1, 1);
        for (int i = 0; i < N; i++) cyc(1, 0, 1, bp, bb);
        chk("basic_vld", out_valid, 1);
        chk("basic_l0", out_data[0 +: DW], 4);
        chk("basic_l9", out_data[9*DW +: DW], 130);
        cyc(0, 0, 1, bp, bb);
        chk("basic_rdy_back", in_ready, 1);

        // Backpressure.
        for (int i = 0; i < N; i++) cyc(1, 0, 0, bp, bb);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, rnd_vec(), rnd_vec());
        chk("bp_l9", out_data[9*DW +: DW], 130);
        cyc(1, 0, 1, rnd_vec(), rnd_vec());
        for (int i = 0; i < N; i++) cyc(1, 0, 1, lanes(2, 3), lanes(5, 7));
        chk("bp_fresh_vld", out_valid, 1);
        chk("bp_fresh_l1", out_data[1*DW +: DW], 12 + 20);
        cyc(0, 0, 1, bp, bb);

        // Flush after two beats.
        one = lanes(1, 0);
        cyc(1, 0, 1, bp, bb);
        cyc(1, 0, 1, bp, bb);
        chk("pre_flush_busy", busy, 1);
        cyc(1, 1, 1, bp, bb);
        chk("flush_busy", busy, 0);
        for (int i = 0; i < N; i++) cyc(1, 0, 1, one, '0);
        for (int k = 0; k < L; k++)
            chk("flush_lane", out_data[k*DW +: DW], 4);
        cyc(0, 0, 1, bp, bb);

        // Flush coincident with the last beat.
        for (int i = 0; i < N - 1; i++) cyc(1, 0, 1, bp, bb);
        cyc(1, 1, 1, bp, bb);
        chk("flush4_vld", out_valid, 0);
        cyc(0, 0, 1, bp, bb);

        // Reset in the middle of a result.
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, bp, bb);
        reset = 1'b1;
        #1;
        grp.delete();
        holding = 1'b0;
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_ready", in_ready, 1);
        chk("rstmid_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) cyc(1, 0, 1, bp, bb);
        chk("rstmid_l0", out_data[0 +: DW], 4);
        chk("rstmid_l9", out_data[9*DW +: DW], 130);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cyc(($urandom % 4) != 0, ($urandom % 20) == 0,
                ($urandom % 2) == 1, rnd_vec(), rnd_vec());

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
